store_result_port: RTL and testbench

STORE_RESULT_PORT -- requirements
Module: store_result_port

---
 rtl/store_result_port_pkg.sv | 15 +
 rtl/store_result_port_fifo.sv | 51 +++++
 rtl/store_result_port.sv | 87 ++++++++
 tb/tb_store_result_port.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_result_port_pkg.sv
// Shared types and default addresses for the store result port.
// Latency: n/a (definitions only). Backpressure: n/a.
package store_result_port_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DONE    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam logic [31:0] DEF_RESULT_ADDR    = 32'd80;
    localparam logic [31:0] DEF_LOG_ADDR       = 32'd84;
    localparam int          DEF_TIMEOUT_CYCLES = 500;

endpackage

// File: rtl/store_result_port_fifo.sv
// Generic log FIFO: registered storage, head visible one cycle after push into empty.
// Latency: 1 cycle push-to-head. Backpressure: push is dropped when full unless a pop happens on the same edge.
module result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);

    // Stale storage is masked so the head reads zero whenever the FIFO is empty.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/store_result_port.sv
// Snoops processor stores: captures the final result, queues trace-log words, runs a watchdog.
// Latency: 1 cycle store-to-flag/head. Backpressure: log words are dropped (overflow) when the FIFO is full.
module store_result_port
    import store_result_port_pkg::*;
#(
    parameter logic [31:0] RESULT_ADDR    = DEF_RESULT_ADDR,
    parameter logic [31:0] LOG_ADDR       = DEF_LOG_ADDR,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] result,
    output logic        done,
    output logic        timeout,
    output logic        overflow,
    output logic [15:0] cycles
);

    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT_CYCLES - 1);

    state_t state;
    logic   accept;
    logic   hit_result;
    logic   hit_log;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;

    assign accept     = memwrite && (state == ST_RUN);
    assign hit_result = accept && (dataadr == RESULT_ADDR);
    assign hit_log    = accept && (dataadr == LOG_ADDR);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;

    result_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hit_log),
        .push_data (writedata),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // cycles only advances while the FSM stays in RUN, so it freezes on the exit edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_RUN;
            result   <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
            cycles   <= '0;
        end else begin
            if (hit_log && fifo_full && !pop) overflow <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (hit_result) begin
                        result <= writedata;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (cycles == LAST_CYCLE) begin
                        timeout <= 1'b1;
                        state   <= ST_TIMEOUT;
                    end else begin
                        cycles <= cycles + 16'd1;
                    end
                end
                ST_DONE:    ;
                ST_TIMEOUT: ;
                default:    state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_store_result_port.sv
// Randomised and directed bench for store_result_port against a queue-based reference model.
module tb_store_result_port;

    localparam int          T     = 20;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RADDR = 32'd80;
    localparam logic [31:0] LADDR = 32'd84;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] result;
    logic        done;
    logic        timeout;
    logic        overflow;
    logic [15:0] cycles;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] drained[$];
    logic [31:0] m_result;
    logic        m_done;
    logic        m_timeout;
    logic        m_overflow;
    int          m_cycles;

    store_result_port #(
        .RESULT_ADDR    (RADDR),
        .LOG_ADDR       (LADDR),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .result    (result),
        .done      (done),
        .timeout   (timeout),
        .overflow  (overflow),
        .cycles    (cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Applies the rules for one clock edge to the model, using the inputs now on the pins.
    task automatic model_edge();
        bit run;
        bit popped;
        if (!reset) begin
            q.delete();
            m_result   = '0;
            m_done     = 1'b0;
            m_timeout  = 1'b0;
            m_overflow = 1'b0;
            m_cycles   = 0;
        end else begin
            run    = !m_done && !m_timeout;
            popped = (q.size() > 0) && out_ready;
            if (popped) void'(q.pop_front());
            if (run && memwrite && dataadr == LADDR) begin
                if (q.size() < DEPTH) q.push_back(writedata);
                else m_overflow = 1'b1;
            end
            if (run && memwrite && dataadr == RADDR) begin
                m_result = writedata;
                m_done   = 1'b1;
            end else if (run && m_cycles == T - 1) begin
                m_timeout = 1'b1;
            end else if (run) begin
                m_cycles++;
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("out_data", out_data, (q.size() != 0) ? q[0] : 32'd0);
        check("result", result, m_result);
        check("done", 32'(done), 32'(m_done));
        check("timeout", 32'(timeout), 32'(m_timeout));
        check("overflow", 32'(overflow), 32'(m_overflow));
        check("cycles", 32'(cycles), 32'(m_cycles));
    endtask

    task automatic step();
        if (reset && out_valid && out_ready) drained.push_back(out_data);
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        memwrite = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = dat;
        step();
        memwrite  = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        memwrite  = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        out_ready = 1'b0;
        q.delete();
        m_result = '0; m_done = 1'b0; m_timeout = 1'b0; m_overflow = 1'b0; m_cycles = 0;
        #1;

        // Reset state
        do_reset();
        step();
        check("rst_cycles_first", 32'(cycles), 32'd1);

        // Result capture in cycle 10 freezes the counter
        do_reset();
        idle(10);
        store(RADDR, 32'hFFFF_FFF9);
        check("res_value", result, 32'hFFFF_FFF9);
        check("res_done", 32'(done), 32'd1);
        check("res_cycles", 32'(cycles), 32'd10);
        idle(3);
        check("res_cycles_frozen", 32'(cycles), 32'd10);

        // Overflow then drain order
        do_reset();
        for (int v = 1; v <= 5; v++) store(LADDR, 32'(v));
        check("ovf_set", 32'(overflow), 32'd1);
        drained.delete();
        out_ready = 1'b1;
        idle(6);
        check("ovf_drain_cnt", 32'(drained.size()), 32'd4);
        for (int i = 0; i < drained.size() && i < 4; i++)
            check("ovf_drain_val", drained[i], 32'(i + 1));

        // Watchdog expiry
        do_reset();
        idle(T - 1);
        check("to_before", 32'(timeout), 32'd0);
        idle(1);
        check("to_set", 32'(timeout), 32'd1);
        store(RADDR, 32'h1234_5678);
        check("to_result", result, 32'd0);
        check("to_done", 32'(done), 32'd0);

        // Result on the expiry cycle wins
        do_reset();
        idle(T - 1);
        store(RADDR, 32'h0000_ABCD);
        check("race_done", 32'(done), 32'd1);
        check("race_timeout", 32'(timeout), 32'd0);
        idle(2);
        check("race_timeout_late", 32'(timeout), 32'd0);

        // Push and pop on the same edge while full
        do_reset();
        for (int v = 10; v <= 13; v++) store(LADDR, 32'(v));
        drained.delete();
        out_ready = 1'b1;
        store(LADDR, 32'd7);
        check("pp_overflow", 32'(overflow), 32'd0);
        idle(6);
        check("pp_drain_cnt", 32'(drained.size()), 32'd5);
        if (drained.size() == 5) check("pp_last", drained[4], 32'd7);

        // Reset mid-operation
        do_reset();
        for (int v = 1; v <= 3; v++) store(LADDR, 32'(v + 100));
        store(RADDR, 32'd55);
        check("mid_pre_done", 32'(done), 32'd1);
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        reset = 1'b1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_result", result, 32'd0);
        check("mid_cycles", 32'(cycles), 32'd0);
        out_ready = 1'b0;
        idle(1);
        check("mid_cycles_next", 32'(cycles), 32'd1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            int sel;
            reset     = ($urandom_range(0, 59) != 0);
            memwrite  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) != 0);
            writedata = $urandom;
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1, 2, 3: dataadr = LADDR;
                4:          dataadr = RADDR;
                5:          dataadr = RADDR | 32'h0000_0100;
                6:          dataadr = LADDR ^ 32'h8000_0000;
                7:          dataadr = LADDR + 32'd1;
                default:    dataadr = $urandom;
            endcase
            step();
            if (done && timeout) check("both_flags", 32'd1, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
